semi_pack: RTL



---
 rtl/semi_pack_pkg.sv | 11 +
 rtl/semi_pack_outbuf.sv | 21 ++
 rtl/semi_pack.sv | 68 ++++++
 3 files changed

// File: rtl/semi_pack_pkg.sv
// semi_pack_pkg: shared video constants and the packed semigraphics byte bundle.
package semi_pack_pkg;
  localparam int PIX_PER_BYTE = 8;
  localparam int COLOUR_W = 4;
  localparam logic [COLOUR_W-1:0] BLACK = '0;
  typedef struct packed {
    logic [PIX_PER_BYTE-1:0] data;
    logic [COLOUR_W-1:0]     colour;
    logic                    error;
  } semi_byte_t;
endpackage

// File: rtl/semi_pack_outbuf.sv
// semi_pack_outbuf: single-entry valid/ready holding register for packed bytes.
module semi_pack_outbuf
  import semi_pack_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  semi_byte_t d,
  input  logic       ready,
  output logic       valid,
  output semi_byte_t q
);
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      valid <= 1'b0;
      q     <= '0;
    end else begin
      valid <= load || (valid && !ready);
      q     <= load ? d : q;
    end
endmodule

// File: rtl/semi_pack.sv
// semi_pack: packs a pixel stream into semigraphics bytes with foreground colour.
module semi_pack #(
  parameter int PIX_PER_BYTE = semi_pack_pkg::PIX_PER_BYTE,
  parameter int COLOUR_W     = semi_pack_pkg::COLOUR_W
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [COLOUR_W-1:0]     colour,
  input  logic                    pixel_valid,
  output logic                    pixel_ready,
  input  logic                    flush,
  output logic [PIX_PER_BYTE-1:0] data,
  output logic [COLOUR_W-1:0]     scolour,
  output logic                    colour_error,
  output logic                    data_valid,
  input  logic                    data_ready
);
  import semi_pack_pkg::*;
  localparam int CW = $clog2(PIX_PER_BYTE) + 1;
  localparam logic [CW-2:0] LAST = (CW-1)'(PIX_PER_BYTE - 1);
  logic [CW-2:0] cnt;
  logic [CW-1:0] c1;
  logic [PIX_PER_BYTE-1:0] acc, a1;
  logic [COLOUR_W-1:0] fg, fg1;
  logic err, err1, pend, take, nz, complete, do_flush, space, load;
  semi_byte_t nb, qb;
  assign pixel_ready = !(data_valid && (cnt == LAST || pend));
  assign take = pixel_valid && pixel_ready;
  assign nz = colour != BLACK;
  assign space = !data_valid || data_ready;
  always_comb begin
    c1 = CW'(cnt) + CW'(take);
    a1 = take ? {acc[PIX_PER_BYTE-2:0], nz} : acc;
    fg1 = (take && fg == BLACK) ? colour : fg;
    err1 = err || (take && nz && fg != BLACK && colour != fg);
    complete = c1 == CW'(PIX_PER_BYTE);
    do_flush = (flush || pend) && c1 != '0 && !complete;
    load = complete || (do_flush && space);
    nb = '{data: a1 << (CW'(PIX_PER_BYTE) - c1), colour: fg1, error: err1};
  end
  // A flush that cannot load stalls with the partial byte intact until the buffer drains.
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      cnt  <= '0;
      acc  <= '0;
      fg   <= BLACK;
      err  <= 1'b0;
      pend <= 1'b0;
    end else begin
      cnt  <= load ? '0 : c1[CW-2:0];
      acc  <= load ? '0 : a1;
      fg   <= load ? BLACK : fg1;
      err  <= load ? 1'b0 : err1;
      pend <= do_flush && !space;
    end
  semi_pack_outbuf u_outbuf (
    .clk   (clk),
    .reset (reset),
    .load  (load),
    .d     (nb),
    .ready (data_ready),
    .valid (data_valid),
    .q     (qb)
  );
  assign data = qb.data;
  assign scolour = qb.colour;
  assign colour_error = qb.error;
endmodule
